memory: RTL and testbench



---
 rtl/memory.sv | 39 +++
 tb/tb_memory.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/memory.sv
// 64 x 4-bit register file holding the Simon pattern sequence.
// Synchronous write, combinational read, asynchronous clear of every entry.
module memory #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_en,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (w_en) begin
            mem_d[w_addr] = w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read straight from the stored array: a same-address write appears only after the edge.
    assign r_data = mem_q[r_addr];

endmodule

// File: tb/tb_memory.sv
// Directed, table-driven check of the Simon pattern memory.
module tb_memory;

    logic       clk;
    logic       rst;
    logic [5:0] r_addr;
    logic [5:0] w_addr;
    logic [3:0] w_data;
    logic       w_en;
    logic [3:0] r_data;

    int checks;
    int failures;

    memory #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .r_addr(r_addr),
        .w_addr(w_addr),
        .w_data(w_data),
        .w_en  (w_en),
        .r_data(r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [5:0] wa;
        logic [3:0] wd;
        logic [5:0] ra;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 64; a++) begin
            r_addr = 6'(a);
            #0.1;
            check($sformatf("%s_addr%0d", name, a), r_data, 4'b0000);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 6'd0,  4'b0001, 6'd0,  4'b0001, "wr0"};
        vecs[1]  = '{1'b1, 6'd1,  4'b0010, 6'd1,  4'b0010, "wr1"};
        vecs[2]  = '{1'b1, 6'd2,  4'b0100, 6'd2,  4'b0100, "wr2"};
        vecs[3]  = '{1'b1, 6'd3,  4'b1000, 6'd3,  4'b1000, "wr3"};
        vecs[4]  = '{1'b0, 6'd4,  4'b0000, 6'd4,  4'b0000, "unwritten4"};
        vecs[5]  = '{1'b0, 6'd2,  4'b1111, 6'd2,  4'b0100, "wen_off2"};
        vecs[6]  = '{1'b1, 6'd63, 4'b1010, 6'd63, 4'b1010, "wr63"};
        vecs[7]  = '{1'b1, 6'd0,  4'b0101, 6'd0,  4'b0101, "wr0_again"};
        vecs[8]  = '{1'b0, 6'd0,  4'b0000, 6'd1,  4'b0010, "keep1"};
        vecs[9]  = '{1'b0, 6'd0,  4'b0000, 6'd3,  4'b1000, "keep3"};
        vecs[10] = '{1'b0, 6'd0,  4'b0000, 6'd62, 4'b0000, "keep62"};
        vecs[11] = '{1'b0, 6'd0,  4'b0000, 6'd63, 4'b1010, "keep63"};

        rst    = 1'b1;
        r_addr = '0;
        w_addr = '0;
        w_data = '0;
        w_en   = 1'b0;

        @(posedge clk);
        #1;
        check_all_zero("init_reset");
        @(negedge clk);
        rst = 1'b0;

        // Async reset clear between edges
        w_en = 1'b1; w_addr = 6'd5; w_data = 4'b1000; r_addr = 6'd5;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        check("pre_reset_addr5", r_data, 4'b1000);
        rst = 1'b1;
        #1;
        check("async_clear_addr5", r_data, 4'b0000);
        check_all_zero("async_clear");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven write/read vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            w_en   = vecs[i].we;
            w_addr = vecs[i].wa;
            w_data = vecs[i].wd;
            r_addr = vecs[i].ra;
            @(posedge clk);
            #1;
            check(vecs[i].name, r_data, vecs[i].exp);
        end

        // Same-address read/write: old value before edge, new after
        @(negedge clk);
        w_en = 1'b1; w_addr = 6'd7; w_data = 4'b0010; r_addr = 6'd7;
        @(negedge clk);
        w_data = 4'b0100;
        #1;
        check("same_addr_before_edge", r_data, 4'b0010);
        @(posedge clk);
        #1;
        check("same_addr_after_edge", r_data, 4'b0100);

        // Different-address write leaves r_data alone
        @(negedge clk);
        w_en = 1'b1; w_addr = 6'd10; w_data = 4'b0001; r_addr = 6'd3;
        #1;
        check("indep_before_edge", r_data, 4'b1000);
        @(posedge clk);
        #1;
        check("indep_after_edge", r_data, 4'b1000);
        r_addr = 6'd10;
        #1;
        check("indep_written10", r_data, 4'b0001);

        // Reset held across an edge with a pending write
        @(negedge clk);
        rst = 1'b1; w_en = 1'b1; w_addr = 6'd9; w_data = 4'b1111;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0; w_en = 1'b0; r_addr = 6'd9;
        #1;
        check("collision_addr9", r_data, 4'b0000);
        r_addr = 6'd7;
        #1;
        check("collision_addr7_cleared", r_data, 4'b0000);

        // Writes resume after reset release
        @(negedge clk);
        w_en = 1'b1; w_addr = 6'd9; w_data = 4'b0011; r_addr = 6'd9;
        @(posedge clk);
        #1;
        check("post_release_wr9", r_data, 4'b0011);
        w_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
